// File: rtl/instruction_mem_loader.sv
// Run-time loader for the instruction memory: assembles little-endian words from a byte
// stream, writes them sequentially and exposes the fetch-stage combinational read port.
module instruction_mem_loader #(
    parameter int unsigned numInstructions = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_end,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        load_done,
    output logic        overflow,
    output logic [7:0]  word_count,
    input  logic [31:0] memAddress,
    output logic [31:0] instruction
);

    localparam int unsigned addrWidth = (numInstructions > 1) ? $clog2(numInstructions) : 1;
    localparam logic [7:0] fullCount = 8'(numInstructions);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} stateT;

    stateT       stateQ, stateD;
    logic [7:0]  wordCountQ, wordCountD;
    logic [1:0]  byteIdxQ, byteIdxD;
    logic [31:0] asmQ, asmD;
    logic        overflowQ, overflowD;

    logic [31:0] mem [numInstructions];

    logic                 memWe;
    logic [addrWidth-1:0] memWaddr;
    logic [31:0]          memWdata;
    logic                 accept;
    logic [31:0]          asmNext;
    logic [7:0]           wordCountInc;
    logic [29:0]          readIdx;

    assign byte_ready   = (stateQ == StLoad);
    assign load_done    = (stateQ == StDone);
    assign overflow     = overflowQ;
    assign word_count   = wordCountQ;
    assign accept       = byte_valid && (stateQ == StLoad);
    assign wordCountInc = wordCountQ + 8'd1;

    always_comb begin
        stateD     = stateQ;
        wordCountD = wordCountQ;
        byteIdxD   = byteIdxQ;
        asmD       = asmQ;
        overflowD  = overflowQ;
        memWe      = 1'b0;
        memWaddr   = wordCountQ[addrWidth-1:0];
        memWdata   = asmQ;
        asmNext    = asmQ;
        if (accept) begin
            asmNext[{byteIdxQ, 3'b000} +: 8] = byte_in;
        end

        unique case (stateQ)
            StIdle: begin
                if (load_start) begin
                    stateD     = StLoad;
                    wordCountD = '0;
                    byteIdxD   = '0;
                    asmD       = '0;
                    overflowD  = 1'b0;
                end
            end
            StLoad: begin
                if (load_start) begin
                    // Restart at word 0; previously written words stay in the array.
                    wordCountD = '0;
                    byteIdxD   = '0;
                    asmD       = '0;
                    overflowD  = 1'b0;
                end else if (accept && (byteIdxQ == 2'd3)) begin
                    memWe      = 1'b1;
                    memWdata   = asmNext;
                    wordCountD = wordCountInc;
                    byteIdxD   = '0;
                    asmD       = '0;
                    if ((wordCountInc == fullCount) || load_end) begin
                        stateD = StDone;
                    end
                end else if (load_end) begin
                    // Flush a partial word; asmQ high bytes are still zero.
                    if (accept || (byteIdxQ != 2'd0)) begin
                        memWe      = 1'b1;
                        memWdata   = asmNext;
                        wordCountD = wordCountInc;
                    end
                    byteIdxD = '0;
                    asmD     = '0;
                    stateD   = StDone;
                end else if (accept) begin
                    asmD     = asmNext;
                    byteIdxD = byteIdxQ + 2'd1;
                end
            end
            StDone: begin
                if (load_start) begin
                    stateD     = StLoad;
                    wordCountD = '0;
                    byteIdxD   = '0;
                    asmD       = '0;
                    overflowD  = 1'b0;
                end else if (byte_valid && (wordCountQ == fullCount)) begin
                    overflowD = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ     <= StIdle;
            wordCountQ <= '0;
            byteIdxQ   <= '0;
            asmQ       <= '0;
            overflowQ  <= 1'b0;
        end else begin
            stateQ     <= stateD;
            wordCountQ <= wordCountD;
            byteIdxQ   <= byteIdxD;
            asmQ       <= asmD;
            overflowQ  <= overflowD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(numInstructions); i++) begin
                mem[i] <= '0;
            end
        end else if (memWe) begin
            mem[memWaddr] <= memWdata;
        end
    end

    assign readIdx = memAddress[31:2];

    always_comb begin
        instruction = '0;
        if ({2'b00, readIdx} < numInstructions) begin
            instruction = mem[readIdx[addrWidth-1:0]];
        end
    end

endmodule

// File: doc/instruction_mem_loader.md
Name: instruction_mem_loader

Overview:
- Write side of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into an internal array of numInstructions words.
- Provides the same combinational word read port the fetch stage uses (memAddress/4 indexing). The datapath can therefore be loaded at run time instead of from a file at elaboration.

Parameters:
- numInstructions, 13, depth of instruction array in 32-bit words (1..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle pulse; starts or restarts a load at word 0.
- load_end  input  1  one-cycle pulse; terminates load early.
- byte_in  input  8  instruction byte, LSB-first within a word.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- load_done  output  1  load complete; memory is stable.
- overflow  output  1  sticky; a byte was offered after the array filled.
- word_count  output  8  number of words written in the current load.
- memAddress  input  32  byte address from fetch.
- instruction  output  32  word at memAddress/4.

Behaviour:
- Reset is asynchronous and active-high. The clock is clk and the reset is reset.
- On reset assertion, immediately and independent of clk:
  - state=IDLE.
  - byte_ready=0, load_done=0, overflow=0, word_count=0.
  - Byte index=0, assembly register=0.
  - All array words=0.
- Reset mid-load discards all partial progress. There is no resume.
- Byte accept: occurs on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is a registered-state decode: 1 only in LOAD.
- Assembly order: byte index k (0..3) goes to bits [8k+7:8k].
- States:
  - IDLE: byte_ready=0, load_done=0. On load_start → LOAD; word_count, byte index, assembly register and overflow are all cleared.
  - LOAD: byte_ready=1.
    - On accepting the 4th byte (index 3), the assembled word is written to array[word_count], word_count increments and the byte index returns to 0, all on the same edge.
    - If word_count becomes numInstructions on that edge → DONE.
    - On load_end → DONE. If the byte index is non-zero, the partial word is first written zero-extended (unreceived high bytes=0) and word_count increments.
    - If a byte is accepted on the same edge as load_end, that byte is included before termination.
    - load_start in LOAD restarts: counters cleared, load continues at word 0. Previously written words are not cleared.
  - DONE: byte_ready=0, load_done=1.
    - byte_valid=1 in DONE with word_count==numInstructions sets overflow (sticky); the byte is dropped.
    - load_start → LOAD with overflow cleared and load_done=0 on the next cycle.
    - load_end is ignored.
- load_start has priority over load_end when both are asserted in the same cycle.
- Read port:
  - Combinational: instruction = array[memAddress/4], i.e. memAddress[31:2].
  - If memAddress/4 >= numInstructions, instruction=0.
  - memAddress[1:0] is ignored.
  - A word written on edge N is visible on instruction after edge N, with no extra latency.
  - Reads are legal in every state and return the words written so far, with unwritten words reading 0 after reset.
- Latency: the 4th byte accepted on edge N makes the word readable and word_count updated after edge N. Full load of numInstructions words takes 4*numInstructions accepting edges minimum.
- Stalls: byte_valid low in LOAD simply holds state; there is no timeout.
- word_count is valid in all states and holds its value in DONE until the next load_start.

Test Plan:
- Reset, then load_start, then bytes 0x13,0x05,0x10,0x00 on 4 consecutive edges → word_count=1; memAddress=0 gives instruction=0x00100513; memAddress=4 gives 0; load_done=0.
- Full load of 13 words (word i = 0xA0000000+i) with byte_valid toggling 1/0 each cycle → load_done=1 after the 52nd accepted byte; word_count=13; memAddress=48 gives 0xA000000C; memAddress=52 gives 0.
- After the full load, byte_valid=1 with byte_in=0xFF for 2 cycles → byte_ready=0, overflow=1 and sticky; array unchanged. Then load_start → overflow=0, state LOAD.
- load_start, bytes 0x6F,0x00 then load_end (3rd byte 0x11 offered on the same edge) → word 0=0x0011006F, word_count=1, load_done=1.
- Assert reset asynchronously mid-word (byte index 2, word_count 5) → outputs and array zero immediately, without waiting for a clk edge; byte_ready=0; instruction=0 for all addresses.
- During LOAD with word_count=3, pulse load_start and load_end together → restart wins: word_count=0, still LOAD, old words 0..2 still readable.
